// File: rtl/mod_arb_pkg.sv
// Shared types and defaults for the Mod_32Bit request arbiter.
package mod_arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_arbiter_if.sv
// Requester and Mod_32Bit unit signals of the arbiter, bundled as one bus.
interface mod_arbiter_if
  import mod_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_result;
  logic                    rsp_err;
  logic                    mod_start;
  logic [DATA_W-1:0]       mod_a;
  logic [DATA_W-1:0]       mod_b;
  logic [DATA_W-1:0]       mod_result;
  logic                    mod_done;

  modport slave (
    input  req_valid, req_a, req_b, mod_result, mod_done,
    output req_ready, rsp_valid, rsp_result, rsp_err, mod_start, mod_a, mod_b
  );

  modport master (
    output req_valid, req_a, req_b, mod_result, mod_done,
    input  req_ready, rsp_valid, rsp_result, rsp_err, mod_start, mod_a, mod_b
  );

endinterface

// File: rtl/mod_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above ptr, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            c;
  logic [IW-1:0] ci;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    ci    = '0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      ci = IW'(c);
      if (!any && req[ci]) begin
        any       = 1'b1;
        grant[ci] = 1'b1;
        idx       = ci;
      end
    end
  end

endmodule

// File: rtl/mod_arbiter.sv
// Shares one Mod_32Bit unit among N_REQ requesters, one operation in flight.
// Grant is visible one cycle after the request is seen; response one cycle after done.
module mod_arbiter
  import mod_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clk,
  input logic          rst,
  mod_arbiter_if.slave bus
);

  localparam int IW = idx_w(N_REQ);

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, w_q, pick_idx;
  logic [N_REQ-1:0]  pick_grant, ready_q, w_oh;
  logic              pick_any, err_q, b_zero;
  logic [DATA_W-1:0] a_q, b_q, res_q, a_sel, b_sel;

  rr_picker #(.N(N_REQ), .IW(IW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign a_sel  = bus.req_a[int'(pick_idx)*DATA_W +: DATA_W];
  assign b_sel  = bus.req_b[int'(pick_idx)*DATA_W +: DATA_W];
  assign b_zero = (b_sel == '0);
  assign w_oh   = N_REQ'(1) << w_q;

  assign bus.req_ready = ready_q;
  assign bus.mod_a     = a_q;
  assign bus.mod_b     = b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.rsp_valid  = '0;
    bus.rsp_result = '0;
    bus.rsp_err    = 1'b0;
    bus.mod_start  = 1'b0;
    case (state_q)
      ST_IDLE:  if (pick_any) state_d = b_zero ? ST_RESP : ST_START;
      ST_START: begin
        bus.mod_start = 1'b1;
        state_d       = ST_WAIT;
      end
      ST_WAIT:  if (bus.mod_done) state_d = ST_RESP;
      ST_RESP:  begin
        bus.rsp_valid  = w_oh;
        bus.rsp_result = res_q;
        bus.rsp_err    = err_q;
        state_d        = ST_DRAIN;
      end
      // A level-held done must fall before the next grant, or it would be taken as a new completion.
      ST_DRAIN: if (!bus.mod_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      w_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= '0;
    end else begin
      ready_q <= '0;
      case (state_q)
        ST_IDLE: if (pick_any) begin
          w_q     <= pick_idx;
          a_q     <= a_sel;
          b_q     <= b_sel;
          ready_q <= pick_grant;
          err_q   <= b_zero;
          res_q   <= b_zero ? a_sel : '0;
        end
        ST_WAIT: if (bus.mod_done) res_q <= bus.mod_result;
        ST_RESP: ptr_q <= (w_q == IW'(N_REQ - 1)) ? '0 : w_q + IW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_arbiter.sv
// Directed bench for mod_arbiter with a scoreboard of expected grants and responses.
module tb_mod_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    int         idx;
    logic [W-1:0] res;
    logic       err;
  } rsp_t;

  logic clk;
  logic rst;

  mod_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus();

  mod_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rsp_t exp_rsp[$];
  int   exp_grant[$];
  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  int   rsp_count = 0;
  int   done_delay = 5;
  int   done_len = 1;
  bit   hold_all = 1'b0;

  int         mcnt;
  int         mon_g;
  logic [N-1:0] mon_oh;
  rsp_t       mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mod_32Bit stand-in: done after done_delay cycles, held done_len cycles, abandoned on reset.
  initial begin
    bus.mod_done   = 1'b0;
    bus.mod_result = '0;
    forever begin
      @(negedge clk);
      if (rst && bus.mod_start) begin
        mcnt = 0;
        while (mcnt < done_delay && rst) begin
          @(negedge clk);
          mcnt++;
        end
        if (rst) begin
          bus.mod_result = bus.mod_a % bus.mod_b;
          bus.mod_done   = 1'b1;
          mcnt = 0;
          while (mcnt < done_len && rst) begin
            @(negedge clk);
            mcnt++;
          end
          bus.mod_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT grants or responds.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mod_start) starts++;
      if (bus.req_ready != '0) begin
        if (exp_grant.size() == 0) chk("unexpected_grant", 64'(bus.req_ready), 0);
        else begin
          mon_g  = exp_grant.pop_front();
          mon_oh = N'(1) << mon_g;
          chk("grant", 64'(bus.req_ready), 64'(mon_oh));
        end
      end
      if (bus.rsp_valid != '0) begin
        rsp_count++;
        if (exp_rsp.size() == 0) chk("unexpected_rsp", 64'(bus.rsp_valid), 0);
        else begin
          mon_e  = exp_rsp.pop_front();
          mon_oh = N'(1) << mon_e.idx;
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(mon_oh));
          chk("rsp_result", 64'(bus.rsp_result), 64'(mon_e.res));
          chk("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (!hold_all) bus.req_valid = bus.req_valid & ~bus.req_ready;
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_valid[i]    = 1'b1;
  endtask

  task automatic expect_op(input int i, input logic [W-1:0] res, input logic err);
    rsp_t e;
    e.idx = i;
    e.res = res;
    e.err = err;
    exp_grant.push_back(i);
    exp_rsp.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || exp_grant.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(exp_rsp.size() + exp_grant.size()), 0);
    exp_rsp.delete();
    exp_grant.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 0);
    chk({tag, "_rsp_result"}, 64'(bus.rsp_result), 0);
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 0);
    chk({tag, "_mod_start"}, 64'(bus.mod_start), 0);
    chk({tag, "_mod_a"}, 64'(bus.mod_a), 0);
    chk({tag, "_mod_b"}, 64'(bus.mod_b), 0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int lat;
    int base;
    bit saw;
    bit fell;

    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b1;
    tick();

    // Single request, latency of grant/start/response.
    issue(0, 50, 13);
    expect_op(0, 11, 1'b0);
    tick();
    chk("ready_cycle1", 64'(bus.req_ready), 64'h1);
    chk("start_cycle1", 64'(bus.mod_start), 1);
    chk("mod_a", 64'(bus.mod_a), 50);
    chk("mod_b", 64'(bus.mod_b), 13);
    lat = 0;
    while (bus.rsp_valid == '0 && lat < 50) begin
      tick();
      lat++;
    end
    chk("rsp_latency", 64'(lat), 6);
    wait_done(100);

    // Two simultaneous requests from pointer 0: req1 then req2.
    do_reset();
    issue(1, 100, 7);
    issue(2, 9, 4);
    expect_op(1, 2, 1'b0);
    expect_op(2, 1, 1'b0);
    wait_done(200);

    // All four continuously valid: rotation 0,1,2,3,0,1,2,3.
    do_reset();
    hold_all = 1'b1;
    issue(0, 20, 6);
    issue(1, 33, 10);
    issue(2, 1000, 999);
    issue(3, 32'hFFFF_FFFF, 16);
    for (int k = 0; k < 2; k++) begin
      expect_op(0, 2, 1'b0);
      expect_op(1, 3, 1'b0);
      expect_op(2, 1, 1'b0);
      expect_op(3, 15, 1'b0);
    end
    for (int i = 0; i < 400 && exp_grant.size() != 0; i++) tick();
    bus.req_valid = '0;
    hold_all      = 1'b0;
    wait_done(400);

    // Divide by zero: no start, dividend echoed with error.
    base = starts;
    issue(3, 77, 0);
    expect_op(3, 77, 1'b1);
    wait_done(50);
    repeat (3) tick();
    chk("no_start_on_zero", 64'(starts - base), 0);

    // Level-held done: single response, next grant only after done falls.
    done_len = 10;
    base     = rsp_count;
    issue(0, 25, 7);
    issue(1, 8, 3);
    expect_op(0, 4, 1'b0);
    expect_op(1, 2, 1'b0);
    saw  = 1'b0;
    fell = 1'b0;
    for (int i = 0; i < 300 && (exp_rsp.size() != 0 || exp_grant.size() != 0); i++) begin
      tick();
      if (bus.mod_done) saw = 1'b1;
      else if (saw) fell = 1'b1;
      if (bus.req_ready[1]) chk("grant_after_done_fall", 64'(fell), 1);
    end
    wait_done(10);
    repeat (15) tick();
    chk("held_done_rsp_count", 64'(rsp_count - base), 2);
    done_len = 1;

    // Reset in the middle of WAIT aborts the op.
    do_reset();
    issue(2, 40, 6);
    exp_grant.push_back(2);
    tick();
    tick();
    tick();
    #2 rst = 1'b0;
    #1 check_outputs_zero("abort");
    tick();
    tick();
    rst = 1'b1;
    base = rsp_count;
    repeat (12) tick();
    chk("aborted_no_rsp", 64'(rsp_count - base), 0);
    chk("aborted_grant_seen", 64'(exp_grant.size()), 0);
    issue(2, 40, 6);
    expect_op(2, 4, 1'b0);
    wait_done(100);

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
